// File: rtl/tick_gen_pkg.sv
// Shared constants and helpers for the tick generator.
// Latency: n/a (compile-time definitions only).
// Backpressure: n/a.
package tick_gen_pkg;

  // Reference clock of the timebase domain.
  localparam int unsigned TICK_CLK_HZ = 24000000;

  // Common divisors derived from the reference clock.
  localparam int unsigned DIV_20HZ = TICK_CLK_HZ / 20;    // 1200000
  localparam int unsigned DIV_1KHZ = TICK_CLK_HZ / 1000;  // 24000

  // Widest divisor the helper handles; DIVW must not exceed this.
  localparam int unsigned DIV_MAXW = 32;

  // Effective divisor: a programmed 0 behaves as 1 (tick every cycle).
  function automatic logic [DIV_MAXW-1:0] div_eff(input logic [DIV_MAXW-1:0] d);
    return (d == '0) ? DIV_MAXW'(1) : d;
  endfunction

endpackage

// File: rtl/tick_chan.sv
// One tick channel: down-counter with shadow/active divisor, tick strobe, optional square wave.
// Latency: tick is registered, high in the cycle after the E-th enabled edge of a period.
// Backpressure: none; en pauses the count, nothing upstream is ever stalled.
// Optional feature macro: TICK_GEN_SQUARE_EN adds the sq output and its toggle flop.
module tick_chan
  import tick_gen_pkg::*;
#(
  parameter int unsigned DIVW        = 21,
  parameter int unsigned DIV_DEFAULT = DIV_20HZ
) (
  input  logic            clk_24M,
  input  logic            reset_n,
  input  logic            en,
  input  logic            restart,
  input  logic            wr,
  input  logic [DIVW-1:0] wr_div,
  output logic            tick
`ifdef TICK_GEN_SQUARE_EN
  ,
  output logic            sq
`endif
);

  localparam logic [DIVW-1:0] ONE     = DIVW'(1);
  localparam logic [DIVW-1:0] DEF_DIV = DIVW'(div_eff(DIV_MAXW'(DIV_DEFAULT)));

  logic [DIVW-1:0] cnt;      // cycles left in the current period, minus one
  logic [DIVW-1:0] div_act;  // divisor of the period in flight
  logic [DIVW-1:0] div_shd;  // divisor for the next period
  logic [DIVW-1:0] wr_eff;   // incoming divisor with 0 mapped to 1
  logic [DIVW-1:0] shd_nxt;  // shadow after this cycle's write
  logic            wrap;     // enabled and at the last cycle of the period
  logic            load_now; // write to a paused channel applies immediately

  // Decode this cycle's write and wrap condition.
  always_comb begin
    wr_eff   = DIVW'(div_eff(DIV_MAXW'(wr_div)));
    shd_nxt  = wr ? wr_eff : div_shd;
    wrap     = en && (cnt == '0);
    load_now = wr && !en;
  end

  // Counter, divisor registers and tick strobe. The wrap reloads from the
  // shadow as it stood before this edge, so a write landing exactly on the
  // wrap only takes effect at the following wrap.
  always_ff @(posedge clk_24M) begin
    if (!reset_n) begin
      div_act <= DEF_DIV;
      div_shd <= DEF_DIV;
      cnt     <= DEF_DIV - ONE;
      tick    <= 1'b0;
    end else if (restart) begin
      div_shd <= shd_nxt;
      div_act <= shd_nxt;
      cnt     <= shd_nxt - ONE;
      tick    <= 1'b0;
    end else begin
      div_shd <= shd_nxt;
      if (load_now) begin
        div_act <= wr_eff;
        cnt     <= wr_eff - ONE;
        tick    <= 1'b0;
      end else if (wrap) begin
        div_act <= div_shd;
        cnt     <= div_shd - ONE;
        tick    <= 1'b1;
      end else begin
        tick <= 1'b0;
        if (en) begin
          cnt <= cnt - ONE;
        end
      end
    end
  end

`ifdef TICK_GEN_SQUARE_EN
  // Square wave: flips on every wrap, cleared by reset and restart.
  always_ff @(posedge clk_24M) begin
    if (!reset_n) begin
      sq <= 1'b0;
    end else if (restart) begin
      sq <= 1'b0;
    end else if (wrap) begin
      sq <= ~sq;
    end
  end
`endif

  // The counter always sits inside the period it was loaded for.
  cnt_in_period: assert property (@(posedge clk_24M) disable iff (!reset_n)
                                  cnt < div_act);

endmodule

// File: rtl/tick_gen.sv
// Multi-channel tick generator: NCH independent divided strobes with a shared restart.
// Latency: cfg write reaches the channel shadow in 1 cycle; ticks are registered.
// Backpressure: none; writes are always accepted (out-of-range channels dropped).
// Optional feature macro: TICK_GEN_SQUARE_EN adds the sq output bus.
module tick_gen
  import tick_gen_pkg::*;
#(
  parameter  int unsigned NCH         = 2,
  parameter  int unsigned DIVW        = 21,
  parameter  int unsigned DIV_DEFAULT = DIV_20HZ,
  localparam int unsigned CHW         = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic            clk_24M,
  input  logic            reset_n,
  input  logic [NCH-1:0]  ch_en,
  input  logic            restart,
  input  logic            cfg_we,
  input  logic [CHW-1:0]  cfg_ch,
  input  logic [DIVW-1:0] cfg_div,
  output logic [NCH-1:0]  tick
`ifdef TICK_GEN_SQUARE_EN
  ,
  output logic [NCH-1:0]  sq
`endif
);

  logic [NCH-1:0] wr_sel;

  // One-hot write select; an index with no matching channel selects nothing.
  always_comb begin
    wr_sel = '0;
    for (int i = 0; i < NCH; i++) begin
      if (cfg_we && (cfg_ch == CHW'(i))) begin
        wr_sel[i] = 1'b1;
      end
    end
  end

  for (genvar g = 0; g < NCH; g++) begin : g_ch
    tick_chan #(
      .DIVW        (DIVW),
      .DIV_DEFAULT (DIV_DEFAULT)
    ) u_chan (
      .clk_24M (clk_24M),
      .reset_n (reset_n),
      .en      (ch_en[g]),
      .restart (restart),
      .wr      (wr_sel[g]),
      .wr_div  (cfg_div),
      .tick    (tick[g])
`ifdef TICK_GEN_SQUARE_EN
      ,
      .sq      (sq[g])
`endif
    );
  end

endmodule

// File: tb/tb_tick_gen.sv
// Directed bench for tick_gen with an elapsed-cycle reference model.
// Latency: n/a.
// Backpressure: n/a.
module tb_tick_gen;

  localparam int NCH  = 3;
  localparam int CHW  = 2;
  localparam int DIVW = 8;
  localparam int DEF  = 4;

  logic            clk_24M;
  logic            reset_n;
  logic [NCH-1:0]  ch_en;
  logic            restart;
  logic            cfg_we;
  logic [CHW-1:0]  cfg_ch;
  logic [DIVW-1:0] cfg_div;
  logic [NCH-1:0]  tick;
`ifdef TICK_GEN_SQUARE_EN
  logic [NCH-1:0]  sq;
`endif

  tick_gen #(
    .NCH         (NCH),
    .DIVW        (DIVW),
    .DIV_DEFAULT (DEF)
  ) dut (
    .clk_24M (clk_24M),
    .reset_n (reset_n),
    .ch_en   (ch_en),
    .restart (restart),
    .cfg_we  (cfg_we),
    .cfg_ch  (cfg_ch),
    .cfg_div (cfg_div),
    .tick    (tick)
`ifdef TICK_GEN_SQUARE_EN
    ,
    .sq      (sq)
`endif
  );

  initial clk_24M = 1'b0;
  always #5 clk_24M = ~clk_24M;

  int n_chk = 0;
  int n_err = 0;
  int edge_n = 0;
  int tlog[NCH][$];

  // Reference model: per channel, the length of the running period, the
  // length queued for the next period, and how many enabled cycles of the
  // running period have elapsed.
  int m_per[NCH];
  int m_pend[NCH];
  int m_el[NCH];
  bit m_tick[NCH];
  bit m_sq[NCH];

  always @(posedge clk_24M) begin
    edge_n++;
    for (int c = 0; c < NCH; c++) begin
      bit w;
      int e;
      w = cfg_we && (int'(cfg_ch) == c);
      e = (cfg_div == 0) ? 1 : int'(cfg_div);
      if (!reset_n) begin
        m_per[c] = DEF; m_pend[c] = DEF; m_el[c] = 0; m_tick[c] = 0; m_sq[c] = 0;
      end else if (restart) begin
        if (w) m_pend[c] = e;
        m_per[c] = m_pend[c]; m_el[c] = 0; m_tick[c] = 0; m_sq[c] = 0;
      end else if (w && !ch_en[c]) begin
        m_pend[c] = e; m_per[c] = e; m_el[c] = 0; m_tick[c] = 0;
      end else begin
        m_tick[c] = 0;
        if (ch_en[c]) begin
          m_el[c]++;
          if (m_el[c] == m_per[c]) begin
            m_tick[c] = 1; m_sq[c] = !m_sq[c]; m_el[c] = 0; m_per[c] = m_pend[c];
          end
        end
        if (w) m_pend[c] = e;
      end
    end
  end

  // Compare DUT against the model every cycle and log tick edges.
  always @(negedge clk_24M) begin
    for (int c = 0; c < NCH; c++) begin
      n_chk++;
      if (tick[c] !== m_tick[c]) begin
        n_err++;
        $display("FAIL model_tick ch%0d edge %0d: got %0b expected %0b", c, edge_n, tick[c], m_tick[c]);
      end
`ifdef TICK_GEN_SQUARE_EN
      n_chk++;
      if (sq[c] !== m_sq[c]) begin
        n_err++;
        $display("FAIL model_sq ch%0d edge %0d: got %0b expected %0b", c, edge_n, sq[c], m_sq[c]);
      end
`endif
      if (tick[c] === 1'b1) tlog[c].push_back(edge_n);
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic adv(input int n);
    repeat (n) begin
      @(negedge clk_24M);
      #1;
    end
  endtask

  task automatic clr_logs();
    for (int c = 0; c < NCH; c++) tlog[c].delete();
  endtask

  task automatic wait_tick(input int c, input int budget, output int at);
    at = -1;
    for (int k = 0; k < budget; k++) begin
      adv(1);
      if (tick[c] === 1'b1) begin
        at = edge_n;
        break;
      end
    end
    n_chk++;
    if (at < 0) begin
      n_err++;
      $display("FAIL wait_tick ch%0d: got no tick expected one within %0d cycles", c, budget);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish by 200000 ns");
    $fatal(1, "bench timeout");
  end

  initial begin
    int t, a, b;
    reset_n = 1'b0;
    ch_en   = '1;
    restart = 1'b0;
    cfg_we  = 1'b0;
    cfg_ch  = '0;
    cfg_div = '0;

    // Reset state.
    adv(3);
    chk("reset_tick", int'(tick), 0);
`ifdef TICK_GEN_SQUARE_EN
    chk("reset_sq", int'(sq), 0);
`endif

    // Release: ticks on the 4th, 8th and 12th edge after release.
    reset_n = 1'b1;
    t = edge_n;
    clr_logs();
    adv(12);
    chk("rel_ch0_n", tlog[0].size(), 3);
    chk("rel_ch0_t0", tlog[0][0], t + 4);
    chk("rel_ch0_t1", tlog[0][1], t + 8);
    chk("rel_ch0_t2", tlog[0][2], t + 12);
    chk("rel_ch1_n", tlog[1].size(), 3);
    chk("rel_ch2_n", tlog[2].size(), 3);
`ifdef TICK_GEN_SQUARE_EN
    chk("rel_sq0", int'(sq[0]), 1);
`endif

    // Divisor 10 written to ch0 mid-period: old period completes first.
    t = edge_n;
    clr_logs();
    cfg_we = 1'b1; cfg_ch = 2'd0; cfg_div = 8'd10;
    adv(1);
    cfg_we = 1'b0;
    adv(23);
    chk("div10_n", tlog[0].size(), 3);
    chk("div10_first", tlog[0][0], t + 4);
    chk("div10_gap1", tlog[0][1] - tlog[0][0], 10);
    chk("div10_gap2", tlog[0][2] - tlog[0][1], 10);
    chk("div10_ch1_n", tlog[1].size(), 6);

    // Divisor 0 to paused ch2, then enable: tick every cycle.
    t = edge_n;
    clr_logs();
    ch_en[2] = 1'b0;
    cfg_we = 1'b1; cfg_ch = 2'd2; cfg_div = 8'd0;
    adv(1);
    cfg_we = 1'b0;
    ch_en[2] = 1'b1;
    adv(6);
    chk("div0_n", tlog[2].size(), 6);
    chk("div0_first", tlog[2][0], t + 2);
    chk("div0_last", tlog[2][5], t + 7);

    // Divisor 5 to ch1 landing on its wrap edge: one more period of 4.
    clr_logs();
    cfg_we = 1'b1; cfg_ch = 2'd1; cfg_div = 8'd5;
    adv(1);
    cfg_we = 1'b0;
    chk("wrapwr_on_edge", int'(tick[1]), 1);
    adv(9);
    chk("wrapwr_n", tlog[1].size(), 3);
    chk("wrapwr_gap_old", tlog[1][1] - tlog[1][0], 4);
    chk("wrapwr_gap_new", tlog[1][2] - tlog[1][1], 5);

    // Pause ch1 for 7 cycles mid-count: that interval stretches to 12.
    b = edge_n;
    adv(2);
    ch_en[1] = 1'b0;
    adv(7);
    ch_en[1] = 1'b1;
    wait_tick(1, 20, a);
    chk("pause_gap", a - b, 12);
    b = a;
    wait_tick(1, 20, a);
    chk("pause_after_gap", a - b, 5);
    chk("pause_ch0_n", tlog[0].size(), 3);
    chk("pause_ch0_gap", tlog[0][2] - tlog[0][1], 10);

    // Write to a channel index that does not exist: ch1 keeps period 5.
    cfg_we = 1'b1; cfg_ch = 2'd3; cfg_div = 8'd7;
    adv(1);
    cfg_we = 1'b0;
    wait_tick(1, 20, b);
    wait_tick(1, 20, a);
    chk("badch_gap", a - b, 5);

    // Reset mid-period: outputs clear, every channel reloads the default.
    reset_n = 1'b0;
    adv(2);
    chk("midrst_tick", int'(tick), 0);
`ifdef TICK_GEN_SQUARE_EN
    chk("midrst_sq", int'(sq), 0);
`endif
    reset_n = 1'b1;
    clr_logs();
    adv(4);
    chk("midrst_first", int'(tick), 7);
    chk("midrst_ch1_n", tlog[1].size(), 1);

    // Restart together with a divisor-3 write to ch1.
    t = edge_n;
    clr_logs();
    restart = 1'b1;
    cfg_we = 1'b1; cfg_ch = 2'd1; cfg_div = 8'd3;
    adv(1);
    restart = 1'b0;
    cfg_we = 1'b0;
    chk("rs_tick", int'(tick), 0);
`ifdef TICK_GEN_SQUARE_EN
    chk("rs_sq", int'(sq), 0);
`endif
    adv(4);
    chk("rs_ch1_first", tlog[1][0], t + 4);
    chk("rs_ch0_first", tlog[0][0], t + 5);
    chk("rs_ch2_first", tlog[2][0], t + 5);
    adv(6);
    chk("rs_ch1_n", tlog[1].size(), 3);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
